// File: rtl/adc_if_seq.sv
// Sequencer for the external 8-bit parallel ADC: paces conversions, drives the
// convst/cs/rd strobes, captures the result and hands it to the filter core.
module adc_if_seq #(
    parameter int SAMPLE_PERIOD = 16,
    parameter int CONVST_W      = 2,
    parameter int RD_W          = 3,
    parameter int EOC_TIMEOUT   = 20,
    parameter int DATA_W        = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ADC_Eoc,
    input  logic [DATA_W-1:0] ADC_Data,
    output logic              ADC_Convst,
    output logic              ADC_cs,
    output logic              ADC_Rd,
    output logic [DATA_W-1:0] Sample_Out,
    output logic              Sample_Valid,
    output logic              Busy,
    output logic              Timeout_Err,
    output logic              Overrun
);

    localparam int CNT_W  = $clog2(SAMPLE_PERIOD) + 1;
    localparam int PH_MAX = (EOC_TIMEOUT > CONVST_W) ?
                            ((EOC_TIMEOUT > RD_W) ? EOC_TIMEOUT : RD_W) :
                            ((CONVST_W > RD_W) ? CONVST_W : RD_W);
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PH_W-1:0]  CONVST_LAST = PH_W'(CONVST_W - 1);
    localparam logic [PH_W-1:0]  RD_LAST     = PH_W'(RD_W - 1);
    localparam logic [PH_W-1:0]  EOC_LAST    = PH_W'(EOC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVST,
        S_WAIT_EOC,
        S_READ
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [PH_W-1:0]  ph_q;
    logic [PH_W-1:0]  ph_n;
    logic             eoc_p0;
    logic             eoc_p1;
    logic             eoc_p2;
    logic             tick;
    logic             eoc_fall;
    logic             to_abort;
    logic             capture;

    assign tick     = (cnt_q == CNT_LAST);
    // eoc_p1 is the synchronised level; eoc_p2 only exists to find its falling edge
    assign eoc_fall = eoc_p2 & ~eoc_p1;

    // ph_q counts cycles spent in the current state and restarts on every transition
    always_comb begin
        state_n  = state_q;
        ph_n     = ph_q + 1'b1;
        to_abort = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ph_n = '0;
                if (tick) begin
                    state_n = S_CONVST;
                end
            end
            S_CONVST: begin
                if (ph_q == CONVST_LAST) begin
                    state_n = S_WAIT_EOC;
                    ph_n    = '0;
                end
            end
            S_WAIT_EOC: begin
                if (eoc_fall) begin
                    state_n = S_READ;
                    ph_n    = '0;
                end else if (ph_q == EOC_LAST) begin
                    state_n  = S_IDLE;
                    ph_n     = '0;
                    to_abort = 1'b1;
                end
            end
            S_READ: begin
                if (ph_q == RD_LAST) begin
                    state_n = S_IDLE;
                    ph_n    = '0;
                    capture = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                ph_n    = '0;
            end
        endcase
    end

    // strobes are decoded from the next state so they line up with the state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            cnt_q        <= '0;
            eoc_p0       <= 1'b1;
            eoc_p1       <= 1'b1;
            eoc_p2       <= 1'b1;
            ADC_Convst   <= 1'b1;
            ADC_cs       <= 1'b1;
            ADC_Rd       <= 1'b1;
            Sample_Out   <= '0;
            Sample_Valid <= 1'b0;
            Busy         <= 1'b0;
            Timeout_Err  <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            cnt_q        <= tick ? '0 : cnt_q + 1'b1;
            eoc_p0       <= ADC_Eoc;
            eoc_p1       <= eoc_p0;
            eoc_p2       <= eoc_p1;
            state_q      <= state_n;
            ph_q         <= ph_n;
            ADC_Convst   <= (state_n != S_CONVST);
            ADC_cs       <= (state_n != S_READ);
            ADC_Rd       <= (state_n != S_READ);
            Busy         <= (state_n != S_IDLE);
            Timeout_Err  <= to_abort;
            Overrun      <= tick && (state_q != S_IDLE);
            Sample_Valid <= capture;
            if (capture) begin
                Sample_Out <= ADC_Data;
            end
        end
    end

endmodule
